alu_iter: RTL and testbench



---
 rtl/alu_iter_pkg.sv | 49 ++++
 rtl/iter_muldiv.sv | 106 ++++++++++
 rtl/alu_iter.sv | 171 +++++++++++++++++
 tb/tb_alu_iter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
// Shared types and helpers for the iterative ALU: op codes, FSM states, compare flags.
package alu_iter_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned NUM_OPS = 17;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_CTZ   = 5'd10,
    OP_CLZ   = 5'd11,
    OP_CPOP  = 5'd12,
    OP_MUL   = 5'd13,
    OP_MULHU = 5'd14,
    OP_DIVU  = 5'd15,
    OP_REMU  = 5'd16
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic less;
    logic greater;
    logic u_less;
    logic u_greater;
  } flags_t;

  function automatic logic is_iterative(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_divide(input logic [OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiplier / restoring divider sharing one 2*XLEN accumulator.
// The first step is folded into the start cycle so XLEN steps finish XLEN-1 cycles later.
module iter_muldiv
  import alu_iter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             done,
  output logic [XLEN-1:0]  prod_lo,
  output logic [XLEN-1:0]  prod_hi,
  output logic [XLEN-1:0]  quot,
  output logic [XLEN-1:0]  rem
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            div_q, div_d;
  logic            done_q, done_d;

  logic [AW-1:0]   acc_src, acc_step;
  logic [XLEN-1:0] b_src;
  logic            div_src;
  logic [XLEN:0]   mul_sum, div_rem, div_diff;

  // One iteration: shift-add for multiply, shift-subtract-restore for divide.
  always_comb begin : step
    acc_src  = start ? {{XLEN{1'b0}}, a} : acc_q;
    b_src    = start ? b : b_q;
    div_src  = start ? is_divide(op) : div_q;
    mul_sum  = {1'b0, acc_src[AW-1:XLEN]} + {1'b0, b_src};
    div_rem  = {acc_src[AW-1:XLEN], acc_src[XLEN-1]};
    div_diff = div_rem - {1'b0, b_src};
    if (div_src) begin
      if (div_diff[XLEN]) begin
        acc_step = {div_rem[XLEN-1:0], acc_src[XLEN-2:0], 1'b0};
      end else begin
        acc_step = {div_diff[XLEN-1:0], acc_src[XLEN-2:0], 1'b1};
      end
    end else if (acc_src[0]) begin
      acc_step = {mul_sum, acc_src[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc_src[AW-1:1]};
    end
  end

  always_comb begin : ctrl
    acc_d  = acc_q;
    b_d    = b_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      acc_d  = acc_step;
      b_d    = b;
      div_d  = is_divide(op);
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_step;
      if (cnt_q == CW'(XLEN - 1)) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      b_q    <= b_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done    = done_q;
  assign prod_lo = acc_q[XLEN-1:0];
  assign prod_hi = acc_q[AW-1:XLEN];
  assign quot    = acc_q[XLEN-1:0];
  assign rem     = acc_q[AW-1:XLEN];

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU with valid/ready handshake: single-cycle ops resolve at accept,
// multiply/divide run through iter_muldiv; result and flags held until consumed.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             less,
  output logic             greater,
  output logic             u_less,
  output logic             u_greater
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  flags_t          flags_q, flags_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  flags_t          flags_c;
  logic [XLEN-1:0] alu_res_c, ctz_c, clz_c, cpop_c, md_res_c;
  logic [SHW-1:0]  shamt_c;
  logic            md_start_c;
  logic            md_done;
  logic [XLEN-1:0] md_prod_lo, md_prod_hi, md_quot, md_rem;

  always_comb begin : compare
    flags_c           = '0;
    flags_c.zero      = (a == b);
    flags_c.less      = ($signed(a) < $signed(b));
    flags_c.greater   = ($signed(a) > $signed(b));
    flags_c.u_less    = (a < b);
    flags_c.u_greater = (a > b);
  end

  // Later writes win: ctz keeps the lowest set bit, clz the highest.
  always_comb begin : bit_count
    ctz_c  = XLEN'(XLEN);
    clz_c  = XLEN'(XLEN);
    cpop_c = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (a[XLEN-1-i]) ctz_c = XLEN'(XLEN - 1 - i);
      if (a[i])        clz_c = XLEN'(XLEN - 1 - i);
      cpop_c = cpop_c + XLEN'(a[i]);
    end
  end

  always_comb begin : single_cycle
    alu_res_c = '0;
    shamt_c   = b[SHW-1:0];
    if (op < OP_W'(NUM_OPS)) begin
      case (op)
        OP_ADD:  alu_res_c = a + b;
        OP_SUB:  alu_res_c = a - b;
        OP_AND:  alu_res_c = a & b;
        OP_OR:   alu_res_c = a | b;
        OP_XOR:  alu_res_c = a ^ b;
        OP_SLL:  alu_res_c = a << shamt_c;
        OP_SRL:  alu_res_c = a >> shamt_c;
        OP_SRA:  alu_res_c = $signed(a) >>> shamt_c;
        OP_SLT:  alu_res_c = XLEN'(flags_c.less);
        OP_SLTU: alu_res_c = XLEN'(flags_c.u_less);
        OP_CTZ:  alu_res_c = ctz_c;
        OP_CLZ:  alu_res_c = clz_c;
        OP_CPOP: alu_res_c = cpop_c;
        default: alu_res_c = '0;
      endcase
    end
  end

  iter_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start_c),
    .op      (op),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .prod_lo (md_prod_lo),
    .prod_hi (md_prod_hi),
    .quot    (md_quot),
    .rem     (md_rem)
  );

  always_comb begin : md_select
    case (op_q)
      OP_MUL:   md_res_c = md_prod_lo;
      OP_MULHU: md_res_c = md_prod_hi;
      OP_DIVU:  md_res_c = md_quot;
      default:  md_res_c = md_rem;
    endcase
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    op_d       = op_q;
    result_d   = result_q;
    flags_d    = flags_q;
    md_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = op;
          flags_d = flags_c;
          if (is_iterative(op)) begin
            md_start_c = 1'b1;
            state_d    = ITER;
          end else begin
            result_d = alu_res_c;
            state_d  = DONE;
          end
        end
      end
      ITER: begin
        if (md_done) begin
          result_d = md_res_c;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign less      = flags_q.less;
  assign greater   = flags_q.greater;
  assign u_less    = flags_q.u_less;
  assign u_greater = flags_q.u_greater;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: stimulus pushes model results, a monitor pops and checks.
module tb_alu_iter;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, less, greater, u_less, u_greater;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    int          acc_cyc;
    logic [4:0]  op;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   rand_bp = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .less      (less),
    .greater   (greater),
    .u_less    (u_less),
    .u_greater (u_greater)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic bit is_iter(input logic [4:0] o);
    return (o == 5'd13) || (o == 5'd14) || (o == 5'd15) || (o == 5'd16);
  endfunction

  function automatic logic [4:0] ref_flags(input logic [31:0] x, input logic [31:0] y);
    return {x == y, $signed(x) < $signed(y), $signed(x) > $signed(y), x < y, x > y};
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] p;
    int n;
    p = {32'b0, x} * {32'b0, y};
    n = 0;
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  return $signed(x) >>> y[4:0];
      5'd8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd10: begin
        while (n < 32 && x[n] == 1'b0) n++;
        return 32'(n);
      end
      5'd11: begin
        while (n < 32 && x[31-n] == 1'b0) n++;
        return 32'(n);
      end
      5'd12: return 32'($countones(x));
      5'd13: return p[31:0];
      5'd14: return p[63:32];
      5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd16: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Caller is aligned at posedge+1; returns aligned one edge after the accept.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      g++;
    end
    chk("issue_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    e.res = ref_result(o, x, y);
    e.flg = ref_flags(x, y);
    e.lat = is_iter(o) ? 33 : 1;
    e.op  = o;
    @(posedge clk); #1;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    op = 5'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || have_cur) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops on the first valid cycle, re-checks every held cycle.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: actual result=%h required no output (cycle %0d)",
                   result, cyc);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk($sformatf("latency op=%0d", cur.op), 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
        end
      end
      if (have_cur) begin
        chk($sformatf("result op=%0d", cur.op), result, cur.res);
        chk($sformatf("flags op=%0d", cur.op),
            {27'b0, zero, less, greater, u_less, u_greater}, {27'b0, cur.flg});
        chk("in_ready_while_valid", 32'(in_ready), 32'd0);
      end
      if (out_ready) have_cur = 1'b0;
    end else if (exp_q.size() != 0) begin
      chk("in_ready_while_busy", 32'(in_ready), 32'd0);
    end
  end

  initial begin
    int g;
    logic [4:0] o;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {27'b0, zero, less, greater, u_less, u_greater}, 32'd0);

    // Arithmetic, shifts, counts, undefined op
    issue(5'd0, 32'd7, 32'd5);
    issue(5'd1, 32'd5, 32'd7);
    issue(5'd7, 32'h8000_0000, 32'd33);
    issue(5'd11, 32'd0, 32'd9);
    issue(5'd10, 32'd0, 32'd3);
    issue(5'd12, 32'hF0F0_F0F0, 32'd0);
    issue(5'd20, 32'd3, 32'd3);

    // Iterative multiply / divide including divide by zero
    issue(5'd13, 32'hFFFF_FFFF, 32'd2);
    issue(5'd14, 32'hFFFF_FFFF, 32'd2);
    issue(5'd15, 32'd100, 32'd7);
    issue(5'd16, 32'd100, 32'd7);
    issue(5'd15, 32'd100, 32'd0);
    issue(5'd16, 32'd100, 32'd0);
    drain();

    // Backpressure: result held, nothing accepted while DONE
    out_ready = 1'b0;
    issue(5'd4, 32'h1234_5678, 32'h0F0F_0F0F);
    g = 0;
    while (!out_valid && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 5'($urandom);
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset during an iterative op
    issue(5'd13, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_late_valid", 32'(out_valid), 32'd0);
    issue(5'd0, 32'd1, 32'd1);
    drain();

    // Randomized ops with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      o = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) o = 5'(13 + $urandom_range(0, 3));
      issue(o, pick(), pick());
    end
    rand_bp = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
